// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: controller state encoding and default width.
package adder_pkg;

  localparam int unsigned ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, the cell time-shared by the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks LSB-first over WIDTH cycles,
// with a start/ready/done handshake toward the host sequencer.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  fa_cell u_fa (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sum/cout/ovf are only touched in RUN, so they hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg <= {1'b0, b_reg[WIDTH-1:1]};
          sum   <= {cell_s, sum[WIDTH-1:1]};
          carry <= cell_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout <= cell_co;
            ovf  <= carry ^ cell_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ovf, cout, sum} from plain integer addition and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xc);
    logic [W:0] full;
    logic       v;
    full = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
    v    = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
    return {v, full};
  endfunction

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, ready, 1);
  endtask

  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input string tag);
    logic [W+1:0] e;
    e = model(xa, xb, xc);
    wait_ready(tag);
    a = xa; b = xb; cin = xc; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= int'(W); i++) begin
      chk({tag, "_run_busy"},  busy,  1);
      chk({tag, "_run_ready"}, ready, 0);
      chk({tag, "_run_done"},  done,  0);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sum"},  sum,  e[W-1:0]);
    chk({tag, "_cout"}, cout, e[W]);
    chk({tag, "_ovf"},  ovf,  e[W+1]);
    step();
    chk({tag, "_done_clr"}, done,  0);
    chk({tag, "_idle_rdy"}, ready, 1);
    chk({tag, "_hold_sum"}, sum,   e[W-1:0]);
  endtask

  initial begin
    int unsigned dcount;
    logic [31:0] dmask;
    logic [W-1:0] held;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_sum",   sum,   0);
    chk("rst_cout",  cout,  0);
    chk("rst_ovf",   ovf,   0);
    rst_n = 1'b1;
    step();

    run_add(8'h5A, 8'h33, 1'b0, "t5a33");
    run_add(8'hFF, 8'h01, 1'b0, "tff01");
    run_add(8'hFF, 8'hFF, 1'b1, "tffff");
    run_add(8'h7F, 8'h00, 1'b1, "t7f00");
    held = sum;
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum",  sum,  held);
      chk("hold_cout", cout, 0);
      chk("hold_ovf",  ovf,  1);
      step();
    end

    // Starts during RUN and DONE must be ignored.
    wait_ready("ign");
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int t = 1; t <= 14; t++) begin
      if (done) begin
        dcount++;
        chk("ign_done_cycle", t, 9);
        chk("ign_sum", sum, 8'h30);
      end
      start = (t == 3 || t == 9);
      a = 8'hAA; b = 8'h55;
      step();
      start = 1'b0;
    end
    chk("ign_done_count", dcount, 1);
    chk("ign_sum_after", sum, 8'h30);

    // Reset in the middle of an operation aborts without a done pulse.
    wait_ready("rstmid");
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstmid_sum",   sum,   0);
    chk("rstmid_cout",  cout,  0);
    chk("rstmid_ovf",   ovf,   0);
    chk("rstmid_ready", ready, 1);
    chk("rstmid_busy",  busy,  0);
    dcount = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) dcount++;
      step();
    end
    chk("rstmid_no_done", dcount, 0);
    run_add(8'h0F, 8'h01, 1'b0, "rstmid_new");

    // start held high: one acceptance every W+2 cycles.
    wait_ready("b2b");
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    dmask = '0;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (done) begin
        dmask[t] = 1'b1;
        chk("b2b_sum", sum, 8'h02);
      end
    end
    start = 1'b0;
    chk("b2b_done_mask", dmask, (32'd1 << 9) | (32'd1 << 19) | (32'd1 << 29));

    for (int i = 0; i < 20; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
